car_sequencer: RTL and testbench

//  Registered, parametrised control-address (CAR) sequencer. Successor to the combinational CAR latch select.

---
 rtl/car_sequencer_pkg.sv | 16 +
 rtl/car_ret_stack.sv | 73 +++++++
 rtl/car_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_car_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/car_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// car_sequencer_pkg
//   Shared constants for the control-address (CAR) sequencer: the control
//   address width and the fixed microcode entry vectors.
//   No ports (package).
// -----------------------------------------------------------------------------
package car_sequencer_pkg;

    localparam int CAR_BITS = 6;

    // Microcode entry points in the control ROM.
    localparam logic [CAR_BITS-1:0] CAR_0    = 6'h00;  // branch / underflow recovery
    localparam logic [CAR_BITS-1:0] CAR_INT0 = 6'h38;  // interrupt entry (pushes context)
    localparam logic [CAR_BITS-1:0] CAR_INT4 = 6'h3C;  // soft-reset entry (no pushes)

endpackage : car_sequencer_pkg

// File: rtl/car_ret_stack.sv
// -----------------------------------------------------------------------------
// car_ret_stack
//   LIFO return-address stack for microcode call/return.
//   Flush has priority over push/pop; a push while full or a pop while empty
//   is ignored here (the caller reports those conditions).
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   i_push          push i_push_data (ignored when full)
//   i_pop           pop top entry (ignored when empty)
//   i_flush         empty the stack
//   i_push_data     WIDTH-bit address to push
//   o_top_data      current top entry (valid when not empty)
//   o_full/o_empty  occupancy status
// -----------------------------------------------------------------------------
module car_ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_push_data,
    output logic [WIDTH-1:0] o_top_data,
    output logic             o_full,
    output logic             o_empty
);

    // Pointer counts 0..DEPTH, so it needs one more code than the index.
    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PW-1:0] P_ONE    = PW'(1);
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    w_top_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_ptr == FULL_CNT);
    assign o_empty    = (r_ptr == '0);
    assign w_do_push  = i_push && !o_full  && !i_flush;
    assign w_do_pop   = i_pop  && !o_empty && !i_flush;
    assign w_top_ptr  = r_ptr - P_ONE;
    assign o_top_data = r_mem[w_top_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_flush) begin
            r_ptr <= '0;
        end else if (w_do_push) begin
            r_ptr <= r_ptr + P_ONE;
        end else if (w_do_pop) begin
            r_ptr <= r_ptr - P_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only ever read
    // after it has been written, and leaving it reset-free keeps it a plain
    // register file.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_ptr[AW-1:0]] <= i_push_data;
        end
    end

endmodule : car_ret_stack

// File: rtl/car_sequencer.sv
// -----------------------------------------------------------------------------
// car_sequencer
//   Registered control-address (CAR) sequencer between the instruction decoder
//   and the control ROM. Owns the CAR register, a latched interrupt-pending
//   bit, a microcode call/return stack and a stall hold.
//   car_next is picked by a fixed priority list (soft reset, stall, interrupt
//   entry, branch, tail jump, call, return, fetch, increment) and loaded into
//   car on every edge.
// Optional feature
//   CAR_DEBUG_HALT_EN : adds dbg_halt / halted. A fetch boundary with dbg_halt
//   high parks the sequencer (car held, decoder address captured) until
//   dbg_halt falls, then resumes at the captured address.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   soft_rst     synchronous reset request (highest priority)
//   intreq       interrupt request, may be a single-cycle pulse
//   if_fetch     instruction-fetch boundary
//   br           PC write-back branch
//   stall        hold car this cycle
//   call, ret    microcode call / return
//   call_tgt     call target address
//   car_new      decoder address for the next instruction
//   car          registered control address
//   car_next     address that will be loaded at the next edge
//   int_ack      one-cycle pulse after interrupt entry is taken
//   stk_ovf      sticky: push attempted while stack full
//   stk_unf      sticky: pop attempted while stack empty
//   dbg_halt     (CAR_DEBUG_HALT_EN) halt request at fetch boundary
//   halted       (CAR_DEBUG_HALT_EN) sequencer parked
// -----------------------------------------------------------------------------
module car_sequencer #(
    parameter int                          CAR_BITS    = car_sequencer_pkg::CAR_BITS,
    parameter int                          STACK_DEPTH = 4,
    parameter logic [CAR_BITS-1:0]         VEC_RST     = car_sequencer_pkg::CAR_INT4,
    parameter logic [CAR_BITS-1:0]         VEC_INT     = car_sequencer_pkg::CAR_INT0,
    parameter logic [CAR_BITS-1:0]         VEC_BR      = car_sequencer_pkg::CAR_0
) (
`ifdef CAR_DEBUG_HALT_EN
    input  logic                dbg_halt,
    output logic                halted,
`endif
    input  logic                clk,
    input  logic                rst_n,
    input  logic                soft_rst,
    input  logic                intreq,
    input  logic                if_fetch,
    input  logic                br,
    input  logic                stall,
    input  logic                call,
    input  logic                ret,
    input  logic [CAR_BITS-1:0] call_tgt,
    input  logic [CAR_BITS-1:0] car_new,
    output logic [CAR_BITS-1:0] car,
    output logic [CAR_BITS-1:0] car_next,
    output logic                int_ack,
    output logic                stk_ovf,
    output logic                stk_unf
);

    localparam logic [CAR_BITS-1:0] CAR_ONE = CAR_BITS'(1);

    logic [CAR_BITS-1:0] r_car;
    logic                r_int_pend;
    logic                r_int_ack;
    logic                r_stk_ovf;
    logic                r_stk_unf;

    logic [CAR_BITS-1:0] w_car_next;
    logic [CAR_BITS-1:0] w_car_inc;
    logic [CAR_BITS-1:0] w_stk_top;
    logic                w_stk_full;
    logic                w_stk_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_flush;
    logic                w_take_int;
    logic                w_set_ovf;
    logic                w_set_unf;
    logic                w_req;

`ifdef CAR_DEBUG_HALT_EN
    logic                r_halted;
    logic [CAR_BITS-1:0] r_hold_addr;
    logic                w_halted_next;
    logic [CAR_BITS-1:0] w_hold_next;
`endif

    // A one-cycle intreq pulse counts immediately, and is remembered in
    // r_int_pend until an entry point (fetch or branch) lets it be taken.
    assign w_req     = intreq | r_int_pend;
    assign w_car_inc = r_car + CAR_ONE;   // wraps modulo 2^CAR_BITS

    car_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (CAR_BITS)
    ) u_ret_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .i_push_data (w_car_inc),
        .o_top_data  (w_stk_top),
        .o_full      (w_stk_full),
        .o_empty     (w_stk_empty)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_car_next = w_car_inc;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_flush    = 1'b0;
        w_take_int = 1'b0;
        w_set_ovf  = 1'b0;
        w_set_unf  = 1'b0;
`ifdef CAR_DEBUG_HALT_EN
        w_halted_next = r_halted;
        w_hold_next   = r_hold_addr;
`endif

        if (soft_rst) begin
            w_car_next = VEC_RST;
            w_flush    = 1'b1;
`ifdef CAR_DEBUG_HALT_EN
            w_halted_next = 1'b0;
        end else if (r_halted) begin
            // Parked: hold until dbg_halt drops, then resume at the captured
            // decoder address. Interrupts stay pending meanwhile.
            if (dbg_halt) begin
                w_car_next = r_car;
            end else begin
                w_car_next    = r_hold_addr;
                w_halted_next = 1'b0;
            end
`endif
        end else if (stall) begin
            w_car_next = r_car;
        end else if (w_req && (if_fetch || br)) begin
            w_car_next = VEC_INT;
            w_take_int = 1'b1;
            w_flush    = 1'b1;
        end else if (br) begin
            w_car_next = VEC_BR;
            w_flush    = 1'b1;
        end else if (call && ret) begin
            // Tail jump: the pop and push cancel, stack untouched.
            w_car_next = call_tgt;
        end else if (call) begin
            w_car_next = call_tgt;
            if (w_stk_full) begin
                w_set_ovf = 1'b1;
            end else begin
                w_push = 1'b1;
            end
        end else if (ret) begin
            if (w_stk_empty) begin
                w_car_next = VEC_BR;
                w_set_unf  = 1'b1;
            end else begin
                w_car_next = w_stk_top;
                w_pop      = 1'b1;
            end
        end else if (if_fetch) begin
            w_flush = 1'b1;
`ifdef CAR_DEBUG_HALT_EN
            if (dbg_halt) begin
                w_car_next    = r_car;
                w_hold_next   = car_new;
                w_halted_next = 1'b1;
            end else begin
                w_car_next = car_new;
            end
`else
            w_car_next = car_new;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_car      <= VEC_RST;
            r_int_pend <= 1'b0;
            r_int_ack  <= 1'b0;
            r_stk_ovf  <= 1'b0;
            r_stk_unf  <= 1'b0;
        end else begin
            r_car     <= w_car_next;
            r_int_ack <= w_take_int;

            if (soft_rst || w_take_int) begin
                r_int_pend <= 1'b0;
            end else if (intreq) begin
                r_int_pend <= 1'b1;
            end

            // Error flags are sticky until a reset of either kind.
            if (soft_rst) begin
                r_stk_ovf <= 1'b0;
                r_stk_unf <= 1'b0;
            end else begin
                r_stk_ovf <= r_stk_ovf | w_set_ovf;
                r_stk_unf <= r_stk_unf | w_set_unf;
            end
        end
    end

`ifdef CAR_DEBUG_HALT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted    <= 1'b0;
            r_hold_addr <= '0;
        end else begin
            r_halted    <= w_halted_next;
            r_hold_addr <= w_hold_next;
        end
    end

    assign halted = r_halted;
`endif

    assign car      = r_car;
    assign car_next = w_car_next;
    assign int_ack  = r_int_ack;
    assign stk_ovf  = r_stk_ovf;
    assign stk_unf  = r_stk_unf;

endmodule : car_sequencer

// File: tb/tb_car_sequencer.sv
// -----------------------------------------------------------------------------
// tb_car_sequencer
//   Self-checking bench for car_sequencer (default build). Every cycle is
//   compared against a queue-based reference model; a vector table and a few
//   hand-written sequences add fixed expected values for the corner cases.
// -----------------------------------------------------------------------------
module tb_car_sequencer;
    import car_sequencer_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       soft_rst, intreq, if_fetch, br, stall, call, ret;
    logic [5:0] call_tgt, car_new;
    logic [5:0] car, car_next;
    logic       int_ack, stk_ovf, stk_unf;

    int n_chk = 0;
    int n_err = 0;

    car_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .soft_rst (soft_rst),
        .intreq   (intreq),
        .if_fetch (if_fetch),
        .br       (br),
        .stall    (stall),
        .call     (call),
        .ret      (ret),
        .call_tgt (call_tgt),
        .car_new  (car_new),
        .car      (car),
        .car_next (car_next),
        .int_ack  (int_ack),
        .stk_ovf  (stk_ovf),
        .stk_unf  (stk_unf)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [5:0] m_car, nx_car;
    logic [5:0] m_stk[$], nx_stk[$];
    logic       m_pend, m_ack, m_ovf, m_unf;
    logic       nx_pend, nx_ack, nx_ovf, nx_unf;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_car  = CAR_INT4;
        m_stk.delete();
        m_pend = 1'b0;
        m_ack  = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Next state from the priority rules, using a queue as the stack.
    task automatic model_eval();
        nx_car  = m_car;
        nx_stk  = m_stk;
        nx_pend = m_pend;
        nx_ovf  = m_ovf;
        nx_unf  = m_unf;
        nx_ack  = 1'b0;
        if (soft_rst) begin
            nx_car = CAR_INT4;
            nx_stk.delete();
            nx_pend = 1'b0;
            nx_ovf  = 1'b0;
            nx_unf  = 1'b0;
        end else if (stall) begin
            if (intreq) nx_pend = 1'b1;
        end else if ((intreq || m_pend) && (if_fetch || br)) begin
            nx_car  = CAR_INT0;
            nx_pend = 1'b0;
            nx_ack  = 1'b1;
            nx_stk.delete();
        end else begin
            if (intreq) nx_pend = 1'b1;
            if (br) begin
                nx_car = CAR_0;
                nx_stk.delete();
            end else if (call && ret) begin
                nx_car = call_tgt;
            end else if (call) begin
                if (nx_stk.size() < DEPTH) nx_stk.push_back(6'((int'(m_car) + 1) % 64));
                else nx_ovf = 1'b1;
                nx_car = call_tgt;
            end else if (ret) begin
                if (nx_stk.size() > 0) nx_car = nx_stk.pop_back();
                else begin
                    nx_car = CAR_0;
                    nx_unf = 1'b1;
                end
            end else if (if_fetch) begin
                nx_car = car_new;
                nx_stk.delete();
            end else begin
                nx_car = 6'((int'(m_car) + 1) % 64);
            end
        end
    endtask

    // One clock: drive inputs, check car_next mid-cycle, clock, check state.
    task automatic cyc(input logic sr, ir, fe, b, st, ca, re,
                       input logic [5:0] tgt, cn);
        soft_rst = sr; intreq = ir; if_fetch = fe; br = b;
        stall = st; call = ca; ret = re; call_tgt = tgt; car_new = cn;
        @(negedge clk);
        model_eval();
        check("car_next", car_next, nx_car);
        @(posedge clk);
        #1;
        m_car = nx_car; m_stk = nx_stk; m_pend = nx_pend;
        m_ack = nx_ack; m_ovf = nx_ovf; m_unf = nx_unf;
        check("car", car, m_car);
        check("int_ack", int_ack, m_ack);
        check("stk_ovf", stk_ovf, m_ovf);
        check("stk_unf", stk_unf, m_unf);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00);
    endtask

    task automatic fetch(input logic [5:0] cn);
        cyc(0, 0, 1, 0, 0, 0, 0, 6'h00, cn);
    endtask

    task automatic do_call(input logic [5:0] tgt);
        cyc(0, 0, 0, 0, 0, 1, 0, tgt, 6'h00);
    endtask

    task automatic do_ret();
        cyc(0, 0, 0, 0, 0, 0, 1, 6'h00, 6'h00);
    endtask

    task automatic do_soft_rst();
        cyc(1, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00);
    endtask

    // Called at posedge+1; asserts rst_n mid-cycle, releases at next posedge+1.
    task automatic async_reset(input bit check_now);
        soft_rst = 0; intreq = 0; if_fetch = 0; br = 0;
        stall = 0; call = 0; ret = 0; call_tgt = '0; car_new = '0;
        #3 rst_n = 1'b0;
        #1;
        if (check_now) begin
            check("rst_car", car, CAR_INT4);
            check("rst_ack", int_ack, 1'b0);
            check("rst_ovf", stk_ovf, 1'b0);
            check("rst_unf", stk_unf, 1'b0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       sr, ir, fe, b, st, ca, re;
        logic [5:0] tgt, cn;
        logic [5:0] e_car;
        logic       e_ack, e_ovf, e_unf;
    } vec_t;

    function automatic vec_t mk(input logic sr, ir, fe, b, st, ca, re,
                                input logic [5:0] tgt, cn, e_car,
                                input logic e_ack, e_ovf, e_unf);
        vec_t v;
        v.sr = sr; v.ir = ir; v.fe = fe; v.b = b; v.st = st; v.ca = ca; v.re = re;
        v.tgt = tgt; v.cn = cn; v.e_car = e_car;
        v.e_ack = e_ack; v.e_ovf = e_ovf; v.e_unf = e_unf;
        return v;
    endfunction

    vec_t vt[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           sr ir fe b st ca re  tgt    cn     e_car  ack ovf unf
        vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 6'h2F, 6'h33, 6'h3D, 0, 0, 0);
        vt[1]  = mk(0, 0, 1, 0, 0, 0, 0, 6'h2F, 6'h05, 6'h05, 0, 0, 0);
        vt[2]  = mk(0, 0, 0, 0, 0, 1, 0, 6'h20, 6'h33, 6'h20, 0, 0, 0);
        vt[3]  = mk(0, 0, 0, 0, 0, 0, 0, 6'h11, 6'h33, 6'h21, 0, 0, 0);
        vt[4]  = mk(0, 0, 0, 0, 0, 0, 1, 6'h11, 6'h33, 6'h06, 0, 0, 0);
        vt[5]  = mk(0, 0, 0, 0, 0, 0, 1, 6'h00, 6'h00, 6'h00, 0, 0, 1);
        vt[6]  = mk(0, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 6'h01, 0, 0, 1);
        vt[7]  = mk(0, 0, 0, 1, 0, 0, 0, 6'h00, 6'h00, 6'h00, 0, 0, 1);
        vt[8]  = mk(0, 0, 0, 0, 0, 1, 1, 6'h2A, 6'h00, 6'h2A, 0, 0, 1);
        vt[9]  = mk(0, 0, 0, 0, 1, 0, 0, 6'h00, 6'h00, 6'h2A, 0, 0, 1);
        vt[10] = mk(0, 1, 0, 0, 1, 0, 0, 6'h00, 6'h00, 6'h2A, 0, 0, 1);
        vt[11] = mk(0, 0, 1, 0, 0, 0, 0, 6'h00, 6'h11, 6'h38, 1, 0, 1);
        vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 6'h39, 0, 0, 1);
        vt[13] = mk(1, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 6'h3C, 0, 0, 0);

        rst_n = 1'b0;
        soft_rst = 0; intreq = 0; if_fetch = 0; br = 0;
        stall = 0; call = 0; ret = 0; call_tgt = '0; car_new = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_car", car, CAR_INT4);
        check("reset_flags", {int_ack, stk_ovf, stk_unf}, 3'b000);
        rst_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 14; i++) begin
            cyc(vt[i].sr, vt[i].ir, vt[i].fe, vt[i].b, vt[i].st, vt[i].ca,
                vt[i].re, vt[i].tgt, vt[i].cn);
            check($sformatf("vec%0d_car", i), car, vt[i].e_car);
            check($sformatf("vec%0d_flags", i), {int_ack, stk_ovf, stk_unf},
                  {vt[i].e_ack, vt[i].e_ovf, vt[i].e_unf});
        end

        // Async reset mid-sequence at car=0x12 with a sticky flag set.
        do_ret();
        check("t1_unf_set", stk_unf, 1'b1);
        fetch(6'h10);
        idle();
        idle();
        check("t1_car12", car, 6'h12);
        async_reset(1'b1);
        check("t1_car_after_release", car, CAR_INT4);
        idle();
        check("t1_inc", car, 6'h3D);

        // Interrupt pulse, taken at a fetch three cycles later.
        fetch(6'h05);
        cyc(0, 1, 0, 0, 0, 0, 0, 6'h00, 6'h00);
        idle();
        idle();
        check("t2_no_ack_yet", int_ack, 1'b0);
        fetch(6'h22);
        check("t2_vec_int", car, CAR_INT0);
        check("t2_ack", int_ack, 1'b1);
        idle();
        check("t2_ack_drop", int_ack, 1'b0);
        fetch(6'h22);
        check("t2_pend_clear", car, 6'h22);

        // Call / return, then nested calls to overflow, then underflow.
        fetch(6'h08);
        do_call(6'h20);
        check("t3_call", car, 6'h20);
        idle();
        check("t3_inc", car, 6'h21);
        do_ret();
        check("t3_ret", car, 6'h09);
        do_call(6'h10);
        do_call(6'h11);
        do_call(6'h12);
        do_call(6'h13);
        check("t3_full_no_ovf", stk_ovf, 1'b0);
        do_call(6'h30);
        check("t3_ovf_car", car, 6'h30);
        check("t3_ovf", stk_ovf, 1'b1);
        do_ret();
        check("t3_pop1", car, 6'h13);
        do_ret();
        check("t3_pop2", car, 6'h12);
        do_ret();
        check("t3_pop3", car, 6'h11);
        do_ret();
        check("t3_pop4", car, 6'h0A);
        do_ret();
        check("t4_unf_car", car, CAR_0);
        check("t4_unf", stk_unf, 1'b1);
        idle();
        idle();
        check("t4_unf_sticky", stk_unf, 1'b1);
        do_soft_rst();
        check("t4_flags_clear", {stk_ovf, stk_unf}, 2'b00);

        // Wrap, then soft_rst beating intreq and if_fetch.
        fetch(6'h3F);
        idle();
        check("t5_wrap", car, 6'h00);
        cyc(1, 1, 1, 0, 0, 0, 0, 6'h00, 6'h19);
        check("t5_soft_rst_car", car, CAR_INT4);
        check("t5_no_ack", int_ack, 1'b0);
        idle();
        check("t5_no_ack_later", int_ack, 1'b0);
        fetch(6'h07);
        check("t5_no_pend", car, 6'h07);

        // Stall beats branch+interrupt; the request stays pending.
        fetch(6'h15);
        cyc(0, 1, 0, 1, 1, 0, 0, 6'h00, 6'h00);
        check("t6_hold", car, 6'h15);
        cyc(0, 0, 0, 1, 0, 0, 0, 6'h00, 6'h00);
        check("t6_int", car, CAR_INT0);
        check("t6_ack", int_ack, 1'b1);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 63) == 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 4) == 0,
                6'($urandom_range(0, 63)),
                6'($urandom_range(0, 63)));
            if ($urandom_range(0, 499) == 0) begin
                async_reset(1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_car_sequencer
